// File: rtl/bsg_array_concentrate_pkg.sv
// Shared definitions for the static array concentrator and deconcentrator.
// Both ends derive the beat-to-row mapping from the same functions here.
package bsg_array_concentrate_pkg;

  typedef enum logic {COLLECT, FULL} state_e;

  function automatic int popcount_pattern(input logic [63:0] pattern);
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(pattern[i]);
    return n;
  endfunction

  // Row index of the k-th set bit, counting from the LSB.
  function automatic int nth_set_bit(input logic [63:0] pattern, input int k);
    int seen = 0;
    int row  = 0;
    for (int i = 0; i < 64; i++) begin
      if (pattern[i]) begin
        if (seen == k) row = i;
        seen++;
      end
    end
    return row;
  endfunction

  function automatic int ctr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

endpackage

// File: rtl/bsg_array_deconcentrate_serial_in_if.sv
// Beat input (valid/ready) and assembled-array output (valid/yumi) bundle.
interface bsg_array_deconcentrate_serial_in_if #(
   parameter int width_p = 128,
   parameter int rows_p  = 5
);
   logic                        v_i;
   logic [width_p-1:0]          data_i;
   logic                        ready_o;
   logic                        v_o;
   logic [rows_p*width_p-1:0]   data_o;
   logic                        yumi_i;

   modport master (output v_i, data_i, yumi_i, input ready_o, v_o, data_o);
   modport slave  (input v_i, data_i, yumi_i, output ready_o, v_o, data_o);
endinterface

// File: rtl/bsg_array_deconcentrate_beat_ctr.sv
// Beat index counter: wraps to zero after els_p-1, with a clear for re-arming.
module bsg_array_deconcentrate_beat_ctr
   import bsg_array_concentrate_pkg::*;
#(
   parameter  int els_p    = 2,
   localparam int width_lp = ctr_width(els_p)
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                incr,
   input  logic                clear,
   output logic [width_lp-1:0] count
);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (incr)
         count <= (count == width_lp'(els_p - 1)) ? '0 : count + width_lp'(1);
   end

endmodule

// File: rtl/bsg_array_deconcentrate_serial_in.sv
// Row-serial receiver: places each beat at its pattern row, zero-fills the rest,
// and presents the full array over a valid/yumi link.
module bsg_array_deconcentrate_serial_in
   import bsg_array_concentrate_pkg::*;
#(
   parameter int width_p   = 128,
   parameter     pattern_p = 5'b10001
) (
   input  logic clk_i,
   input  logic reset_n_i,
   bsg_array_deconcentrate_serial_in_if.slave link
);

   localparam int rows_p       = $bits(pattern_p);
   localparam int els_p        = popcount_pattern(64'(pattern_p));
   localparam int ctr_width_lp = ctr_width(els_p);

   function automatic logic [els_p-1:0][rows_p-1:0] build_row_lut();
      logic [els_p-1:0][rows_p-1:0] lut;
      for (int k = 0; k < els_p; k++)
         lut[k] = rows_p'(1) << nth_set_bit(64'(pattern_p), k);
      return lut;
   endfunction

   localparam logic [els_p-1:0][rows_p-1:0] row_lut = build_row_lut();

   state_e                          state_q, state_d;
   logic [ctr_width_lp-1:0]         count;
   logic                            accept, last, clear;
   logic [rows_p-1:0]               we;
   logic [rows_p-1:0][width_p-1:0]  data_q;

   assign link.v_o     = (state_q == FULL);
   assign link.ready_o = reset_n_i & (~link.v_o | link.yumi_i);
   assign accept       = link.v_i & link.ready_o;
   assign last         = (count == ctr_width_lp'(els_p - 1));
   // Re-arm at beat 0 when an array is released without a new beat arriving.
   assign clear        = link.v_o & link.yumi_i & ~accept;

   bsg_array_deconcentrate_beat_ctr #(.els_p(els_p)) beat_ctr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .incr      (accept),
      .clear     (clear),
      .count     (count)
   );

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= COLLECT;
      else            state_q <= state_d;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      if (accept && last)   state_d = FULL;
      else if (link.yumi_i) state_d = COLLECT;
   end

   always_comb begin
      we = '0;
      for (int k = 0; k < els_p; k++)
         if (accept && count == ctr_width_lp'(k)) we = we | row_lut[k];
   end

   // NOTE: the row storage is reset because unselected rows must read as zero and data_o is 0 out of reset.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         data_q <= '0;
      end else begin
         for (int r = 0; r < rows_p; r++)
            if (we[r]) data_q[r] <= link.data_i;
      end
   end

   assign link.data_o = data_q;

endmodule
